// File: rtl/m_ext_issue_unit_if.sv
// ----------------------------------------------------------------------------
// m_ext_issue_unit_if
//   Bundles every non-clock signal of the M-extension issue unit. Signal names
//   keep the direction suffix as seen from the issue unit itself.
//
//   Core side   : in_valid_i/in_ready_o, opcode_i, funct3_i, funct7_i, rs1_i,
//                 rs2_i, tag_i, match_o, out_valid_o/out_ready_i, result_o,
//                 tag_o
//   Unit side   : mul_req_o, div_req_o, op_a_o, op_b_o, signed_A_o,
//                 signed_B_o, upper_rem_o, unit_ready_i, unit_done_i,
//                 unit_result_i
//
//   Modports:
//     slave  - the issue unit
//     master - the environment (core plus multiplier/divider)
// ----------------------------------------------------------------------------
interface m_ext_issue_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [6:0]       opcode_i;
  logic [2:0]       funct3_i;
  logic [6:0]       funct7_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [TAG_W-1:0] tag_i;
  logic             match_o;
  logic             mul_req_o;
  logic             div_req_o;
  logic [XLEN-1:0]  op_a_o;
  logic [XLEN-1:0]  op_b_o;
  logic             signed_A_o;
  logic             signed_B_o;
  logic             upper_rem_o;
  logic             unit_ready_i;
  logic             unit_done_i;
  logic [XLEN-1:0]  unit_result_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] tag_o;

  modport slave (
    input  in_valid_i, opcode_i, funct3_i, funct7_i, rs1_i, rs2_i, tag_i,
           unit_ready_i, unit_done_i, unit_result_i, out_ready_i,
    output in_ready_o, match_o, mul_req_o, div_req_o, op_a_o, op_b_o,
           signed_A_o, signed_B_o, upper_rem_o, out_valid_o, result_o, tag_o
  );

  modport master (
    output in_valid_i, opcode_i, funct3_i, funct7_i, rs1_i, rs2_i, tag_i,
           unit_ready_i, unit_done_i, unit_result_i, out_ready_i,
    input  in_ready_o, match_o, mul_req_o, div_req_o, op_a_o, op_b_o,
           signed_A_o, signed_B_o, upper_rem_o, out_valid_o, result_o, tag_o
  );
endinterface

// File: rtl/m_ext_issue_unit.sv
// ----------------------------------------------------------------------------
// m_ext_issue_unit
//   Sequential front-end for an M-extension multiplier/divider. Accepts one
//   decoded M instruction at a time, latches operands, tag and control bits,
//   issues a single request to the multiplier or divider, waits for the unit's
//   done pulse and then holds the result on a valid/ready response port.
//
//   Ports:
//     clk_i    - clock, all state on the rising edge
//     rst_n_i  - asynchronous active-low reset
//     bus      - m_ext_issue_unit_if.slave (core request/response and
//                multiplier/divider request/result signals)
//
//   Optional feature macro: M_DIV_SPECIAL_BYPASS_EN
//     When defined, divide-class instructions with a zero divisor or the
//     signed overflow case (most-negative / -1) are answered directly from
//     IDLE without issuing to the divider (RISC-V defined results).
//     When undefined, every instruction goes through ISSUE/WAIT.
// ----------------------------------------------------------------------------
module m_ext_issue_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  m_ext_issue_unit_if.slave    bus
);

  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   op_a_q, op_a_d;
  logic [XLEN-1:0]   op_b_q, op_b_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              is_div_q, is_div_d;
  logic              signed_a_q, signed_a_d;
  logic              signed_b_q, signed_b_d;
  logic              upper_q, upper_d;

  logic              match;
  logic              accept;
  logic              dec_signed_a;
  logic              dec_signed_b;
  logic              dec_upper;

  // Operand signedness and high-half/remainder select per funct3.
  // 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
  function automatic logic [2:0] decode_ctrl(input logic [2:0] f3);
    logic [2:0] ctl;
    case (f3)
      3'b000:  ctl = 3'b110;
      3'b001:  ctl = 3'b111;
      3'b010:  ctl = 3'b101;
      3'b011:  ctl = 3'b001;
      3'b100:  ctl = 3'b110;
      3'b101:  ctl = 3'b000;
      3'b110:  ctl = 3'b111;
      default: ctl = 3'b001;
    endcase
    return ctl;
  endfunction

`ifdef M_DIV_SPECIAL_BYPASS_EN
  localparam logic signed [XLEN-1:0] MOST_NEG_S = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic signed [XLEN-1:0] NEG_ONE_S  = '1;

  // Zero divisor (any div-class op) or signed overflow (DIV/REM only, funct3[0]==0).
  function automatic logic div_is_special(input logic [2:0]      f3,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    return (b == '0) || (!f3[0] && (sa == MOST_NEG_S) && (sb == NEG_ONE_S));
  endfunction

  // funct3[1] separates remainder ops from quotient ops.
  function automatic logic [XLEN-1:0] div_special_value(input logic [2:0]      f3,
                                                        input logic [XLEN-1:0] a,
                                                        input logic [XLEN-1:0] b);
    if (b == '0) begin
      return f3[1] ? a : '1;
    end
    return f3[1] ? '0 : MOST_NEG_S;
  endfunction
`endif

  assign match  = (bus.opcode_i == OPC_OP) && (bus.funct7_i == FUNCT7_M);
  assign accept = bus.in_valid_i && (state_q == S_IDLE) && match;
  assign {dec_signed_a, dec_signed_b, dec_upper} = decode_ctrl(bus.funct3_i);

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    result_d   = result_q;
    tag_d      = tag_q;
    is_div_d   = is_div_q;
    signed_a_d = signed_a_q;
    signed_b_d = signed_b_q;
    upper_d    = upper_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_a_d     = bus.rs1_i;
          op_b_d     = bus.rs2_i;
          tag_d      = bus.tag_i;
          is_div_d   = bus.funct3_i[2];
          signed_a_d = dec_signed_a;
          signed_b_d = dec_signed_b;
          upper_d    = dec_upper;
          state_d    = S_ISSUE;
`ifdef M_DIV_SPECIAL_BYPASS_EN
          if (bus.funct3_i[2] && div_is_special(bus.funct3_i, bus.rs1_i, bus.rs2_i)) begin
            result_d = div_special_value(bus.funct3_i, bus.rs1_i, bus.rs2_i);
            state_d  = S_RESP;
          end
`endif
        end
      end
      // Request is held high for the whole ISSUE state.
      S_ISSUE: begin
        if (bus.unit_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.unit_done_i) begin
          result_d = bus.unit_result_i;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      result_q   <= '0;
      tag_q      <= '0;
      is_div_q   <= 1'b0;
      signed_a_q <= 1'b0;
      signed_b_q <= 1'b0;
      upper_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      result_q   <= result_d;
      tag_q      <= tag_d;
      is_div_q   <= is_div_d;
      signed_a_q <= signed_a_d;
      signed_b_q <= signed_b_d;
      upper_q    <= upper_d;
    end
  end

  // Handshake outputs are pure state decodes so an async reset drops them at once.
  assign bus.match_o     = match;
  assign bus.in_ready_o  = (state_q == S_IDLE);
  assign bus.mul_req_o   = (state_q == S_ISSUE) && !is_div_q;
  assign bus.div_req_o   = (state_q == S_ISSUE) &&  is_div_q;
  assign bus.out_valid_o = (state_q == S_RESP);
  assign bus.op_a_o      = op_a_q;
  assign bus.op_b_o      = op_b_q;
  assign bus.signed_A_o  = signed_a_q;
  assign bus.signed_B_o  = signed_b_q;
  assign bus.upper_rem_o = upper_q;
  assign bus.result_o    = result_q;
  assign bus.tag_o       = tag_q;

endmodule

// File: tb/tb_m_ext_issue_unit.sv
module tb_m_ext_issue_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
`ifdef M_DIV_SPECIAL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  m_ext_issue_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
  m_ext_issue_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension arithmetic, computed directly with wide integers.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    int              sa, sb;
    longint          ps;
    longint unsigned pu;
    logic [31:0]     r;
    sa = a;
    sb = b;
    case (f3)
      3'd0: r = a * b;
      3'd1: begin ps = longint'(sa) * longint'(sb); r = ps[63:32]; end
      3'd2: begin ps = longint'(sa) * longint'({32'h0, b}); r = ps[63:32]; end
      3'd3: begin pu = {32'h0, a} * {32'h0, b}; r = pu[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a :
                ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // {signed_A, signed_B, upper_rem} for MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
  function automatic logic [2:0] ref_ctrl(input logic [2:0] f3);
    logic [2:0] tbl [8];
    tbl = '{3'b110, 3'b111, 3'b101, 3'b001, 3'b110, 3'b000, 3'b111, 3'b001};
    return tbl[f3];
  endfunction

  function automatic bit ref_special(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    bit signed_div;
    signed_div = (f3 == 3'd4) || (f3 == 3'd6);
    return f3[2] && ((b == 0) || (signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic drive_instr(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] tg);
    bus.opcode_i = 7'b0110011;
    bus.funct7_i = 7'b0000001;
    bus.funct3_i = f3;
    bus.rs1_i    = a;
    bus.rs2_i    = b;
    bus.tag_i    = tg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at #1 after a rising edge with the DUT in IDLE.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tg, input int rdy_dly, input int done_dly,
                        input int ordy_dly);
    logic [2:0]  ctl;
    logic [31:0] exp_res;
    logic [1:0]  exp_req;
    bit          byp;
    ctl     = ref_ctrl(f3);
    exp_res = ref_result(f3, a, b);
    exp_req = f3[2] ? 2'b01 : 2'b10;
    byp     = BYPASS && ref_special(f3, a, b);

    chk("in_ready_idle", bus.in_ready_o, 1'b1);
    drive_instr(f3, a, b, tg);
    bus.in_valid_i = 1'b1;
    #1;
    chk("match_m", bus.match_o, 1'b1);
    tick();
    bus.in_valid_i = 1'b0;
    drive_instr(3'($urandom), $urandom, $urandom, 5'($urandom));
    chk("ctrl_bits", {bus.signed_A_o, bus.signed_B_o, bus.upper_rem_o}, ctl);
    chk("op_a", bus.op_a_o, a);
    chk("op_b", bus.op_b_o, b);

    if (byp) begin
      chk("bypass_no_req", {bus.mul_req_o, bus.div_req_o}, 2'b00);
    end else begin
      for (int i = 0; i < rdy_dly; i++) begin
        chk("req_hold", {bus.mul_req_o, bus.div_req_o}, exp_req);
        chk("op_a_hold", bus.op_a_o, a);
        chk("in_ready_busy", bus.in_ready_o, 1'b0);
        bus.unit_done_i = 1'b1;
        bus.unit_result_i = $urandom;
        tick();
        bus.unit_done_i = 1'b0;
      end
      chk("req", {bus.mul_req_o, bus.div_req_o}, exp_req);
      bus.unit_ready_i = 1'b1;
      tick();
      for (int i = 0; i < done_dly; i++) begin
        chk("req_low_wait", {bus.mul_req_o, bus.div_req_o}, 2'b00);
        chk("no_valid_wait", bus.out_valid_o, 1'b0);
        tick();
      end
      bus.unit_ready_i  = 1'b0;
      chk("req_low_done", {bus.mul_req_o, bus.div_req_o}, 2'b00);
      bus.unit_done_i   = 1'b1;
      bus.unit_result_i = exp_res;
      tick();
      bus.unit_done_i   = 1'b0;
      bus.unit_result_i = $urandom;
    end

    for (int i = 0; i <= ordy_dly; i++) begin
      chk("out_valid", bus.out_valid_o, 1'b1);
      chk("result", bus.result_o, exp_res);
      chk("tag", bus.tag_o, tg);
      chk("in_ready_resp", bus.in_ready_o, 1'b0);
      chk("op_a_resp", bus.op_a_o, a);
      if (i < ordy_dly) begin
        drive_instr(3'($urandom), $urandom, $urandom, 5'($urandom));
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b0;
        #1;
        chk("match_busy", bus.match_o, 1'b1);
      end else begin
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
      end
      tick();
    end
    bus.out_ready_i = 1'b0;
    chk("resp_done_valid", bus.out_valid_o, 1'b0);
    chk("resp_done_idle", bus.in_ready_o, 1'b1);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.unit_ready_i = 1'b0;
    bus.unit_done_i = 1'b0;
    bus.unit_result_i = '0;
    drive_instr(3'd0, 32'd0, 32'd0, 5'd0);

    // Reset state
    tick();
    chk("rst_in_ready", bus.in_ready_o, 1'b1);
    chk("rst_out_valid", bus.out_valid_o, 1'b0);
    chk("rst_req", {bus.mul_req_o, bus.div_req_o}, 2'b00);
    chk("rst_ctrl", {bus.signed_A_o, bus.signed_B_o, bus.upper_rem_o}, 3'b000);
    chk("rst_data", {bus.op_a_o, bus.op_b_o}, 64'h0);
    chk("rst_result", bus.result_o, 32'h0);
    chk("rst_tag", bus.tag_o, 5'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // MUL 7 * -3, done two cycles after the request is taken
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 0, 1, 0);
    // MULHU with unit_ready low 4 cycles
    run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3, 4, 0, 0);
    // Response back-pressure for 3 cycles with new offers ignored
    run_op(3'd1, 32'h8000_0001, 32'h7FFF_FFFF, 5'd30, 1, 2, 3);

    // ADD: opcode matches but funct7 does not -> not accepted
    drive_instr(3'd0, 32'h1111_1111, 32'h2222_2222, 5'd1);
    bus.funct7_i   = 7'b0000000;
    bus.in_valid_i = 1'b1;
    #1;
    chk("add_match", bus.match_o, 1'b0);
    tick();
    chk("add_idle", bus.in_ready_o, 1'b1);
    chk("add_no_req", {bus.mul_req_o, bus.div_req_o}, 2'b00);
    chk("add_op_a_kept", bus.op_a_o, 32'h8000_0001);
    bus.in_valid_i = 1'b0;

    // Divide special cases (bypassed or through the divider, depending on build)
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 0, 0, 0);
    run_op(3'd7, 32'd5, 32'd0, 5'd18, 0, 0, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 0, 0, 1);
    run_op(3'd5, 32'd100, 32'd7, 5'd20, 2, 1, 0);

    // Asynchronous reset while waiting for the unit
    drive_instr(3'd2, 32'h0000_0040, 32'h0000_0003, 5'd7);
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
    bus.unit_ready_i = 1'b1;
    tick();
    bus.unit_ready_i = 1'b0;
    chk("wait_not_idle", bus.in_ready_o, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid_o, 1'b0);
    chk("arst_in_ready", bus.in_ready_o, 1'b1);
    chk("arst_req", {bus.mul_req_o, bus.div_req_o}, 2'b00);
    chk("arst_op_a", bus.op_a_o, 32'h0);
    tick();
    rst_n = 1'b1;
    bus.unit_done_i = 1'b1;
    bus.unit_result_i = 32'hDEAD_BEEF;
    tick();
    bus.unit_done_i = 1'b0;
    chk("late_done_valid", bus.out_valid_o, 1'b0);
    chk("late_done_idle", bus.in_ready_o, 1'b1);
    chk("late_done_result", bus.result_o, 32'h0);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(f3, a, b, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
